// File: rtl/axi_mem_responder.sv
// AXI4 slave memory responder: INCR bursts on a 512-bit port backed by a
// 2^ADDR_BITS-word array, with byte strobes and SLVERR for bad size/range.
module axi_mem_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned ID_BITS   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ID_BITS-1:0] arid_s,
    input  logic [63:0]        araddr_s,
    input  logic [7:0]         arlen_s,
    input  logic [2:0]         arsize_s,
    input  logic               arvalid_s,
    output logic               arready_s,
    output logic [ID_BITS-1:0] rid_s,
    output logic [511:0]       rdata_s,
    output logic [1:0]         rresp_s,
    output logic               rlast_s,
    output logic               rvalid_s,
    input  logic               rready_s,
    input  logic [ID_BITS-1:0] awid_s,
    input  logic [63:0]        awaddr_s,
    input  logic [7:0]         awlen_s,
    input  logic [2:0]         awsize_s,
    input  logic               awvalid_s,
    output logic               awready_s,
    input  logic [511:0]       wdata_s,
    input  logic [63:0]        wstrb_s,
    input  logic               wlast_s,
    input  logic               wvalid_s,
    output logic               wready_s,
    output logic [ID_BITS-1:0] bid_s,
    output logic [1:0]         bresp_s,
    output logic               bvalid_s,
    input  logic               bready_s
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [511:0] mem_q [DEPTH];

    // Address-channel readies stay low until the first edge after reset release.
    logic ready_en_q;

    r_state_e           r_state_q, r_state_d;
    logic [ID_BITS-1:0] r_id_q, r_id_d;
    logic [57:0]        r_idx_q, r_idx_d;
    logic [7:0]         r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic               r_szerr_q, r_szerr_d;
    logic [511:0]       rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic               r_err, r_last;

    w_state_e           w_state_q, w_state_d;
    logic [ID_BITS-1:0] w_id_q, w_id_d;
    logic [57:0]        w_idx_q, w_idx_d;
    logic [7:0]         w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic               w_szerr_q, w_szerr_d;
    logic               w_flag_q, w_flag_d;
    logic               w_err, w_last, mem_we;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{araddr_s[5:0], awaddr_s[5:0]};

    assign r_err  = r_szerr_q || ((r_idx_q >> ADDR_BITS) != '0);
    assign r_last = (r_cnt_q == r_len_q);
    assign w_err  = w_szerr_q || ((w_idx_q >> ADDR_BITS) != '0);
    assign w_last = (w_cnt_q == w_len_q);
    assign mem_we = (w_state_q == W_DATA) && wvalid_s && !w_err;

    assign arready_s = ready_en_q && (r_state_q == R_IDLE);
    assign rvalid_s  = (r_state_q == R_DATA);
    assign rlast_s   = (r_state_q == R_DATA) && r_last;
    assign rid_s     = r_id_q;
    assign rdata_s   = rdata_q;
    assign rresp_s   = rresp_q;

    assign awready_s = ready_en_q && (w_state_q == W_IDLE);
    assign wready_s  = (w_state_q == W_DATA);
    assign bvalid_s  = (w_state_q == W_RESP);
    assign bid_s     = w_id_q;
    assign bresp_s   = ((w_state_q == W_RESP) && w_flag_q) ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 64; i++) begin
                if (wstrb_s[i]) mem_q[w_idx_q[ADDR_BITS-1:0]][8*i +: 8] <= wdata_s[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en_q <= 1'b0;
            r_state_q  <= R_IDLE;
            r_id_q     <= '0;
            r_idx_q    <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
            r_szerr_q  <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            w_state_q  <= W_IDLE;
            w_id_q     <= '0;
            w_idx_q    <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_szerr_q  <= 1'b0;
            w_flag_q   <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            r_state_q  <= r_state_d;
            r_id_q     <= r_id_d;
            r_idx_q    <= r_idx_d;
            r_len_q    <= r_len_d;
            r_cnt_q    <= r_cnt_d;
            r_szerr_q  <= r_szerr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            w_state_q  <= w_state_d;
            w_id_q     <= w_id_d;
            w_idx_q    <= w_idx_d;
            w_len_q    <= w_len_d;
            w_cnt_q    <= w_cnt_d;
            w_szerr_q  <= w_szerr_d;
            w_flag_q   <= w_flag_d;
        end
    end

    // Array read happens in R_FETCH, so a same-cycle write to that word is not seen.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_szerr_d = r_szerr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid_s && arready_s) begin
                    r_id_d    = arid_s;
                    r_idx_d   = araddr_s[63:6];
                    r_len_d   = arlen_s;
                    r_cnt_d   = '0;
                    r_szerr_d = (arsize_s != 3'b110);
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rdata_d   = r_err ? '0 : mem_q[r_idx_q[ADDR_BITS-1:0]];
                rresp_d   = r_err ? 2'b10 : 2'b00;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (rready_s) begin
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d   = r_idx_q + 58'd1;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_szerr_d = w_szerr_q;
        w_flag_d  = w_flag_q;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid_s && awready_s) begin
                    w_id_d    = awid_s;
                    w_idx_d   = awaddr_s[63:6];
                    w_len_d   = awlen_s;
                    w_cnt_d   = '0;
                    w_szerr_d = (awsize_s != 3'b110);
                    w_flag_d  = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid_s) begin
                    if (w_err || (wlast_s != w_last)) w_flag_d = 1'b1;
                    if (w_last) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_idx_d = w_idx_q + 58'd1;
                        w_cnt_d = w_cnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bready_s) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomised bench for axi_mem_responder against an array-based reference of
// burst addressing, strobe merging and error response rules.
module tb_axi_mem_responder;

    localparam int unsigned AB    = 6;
    localparam int unsigned IDW   = 16;
    localparam int unsigned WORDS = 1 << AB;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [IDW-1:0] arid_s, rid_s, awid_s, bid_s;
    logic [63:0]    araddr_s, awaddr_s, wstrb_s;
    logic [7:0]     arlen_s, awlen_s;
    logic [2:0]     arsize_s, awsize_s;
    logic           arvalid_s, arready_s, rlast_s, rvalid_s, rready_s;
    logic           awvalid_s, awready_s, wlast_s, wvalid_s, wready_s;
    logic           bvalid_s, bready_s;
    logic [511:0]   rdata_s, wdata_s;
    logic [1:0]     rresp_s, bresp_s;

    always #5 clk = ~clk;

    axi_mem_responder #(.ADDR_BITS(AB), .ID_BITS(IDW)) dut (
        .clk(clk), .reset_n(reset_n),
        .arid_s(arid_s), .araddr_s(araddr_s), .arlen_s(arlen_s), .arsize_s(arsize_s),
        .arvalid_s(arvalid_s), .arready_s(arready_s),
        .rid_s(rid_s), .rdata_s(rdata_s), .rresp_s(rresp_s), .rlast_s(rlast_s),
        .rvalid_s(rvalid_s), .rready_s(rready_s),
        .awid_s(awid_s), .awaddr_s(awaddr_s), .awlen_s(awlen_s), .awsize_s(awsize_s),
        .awvalid_s(awvalid_s), .awready_s(awready_s),
        .wdata_s(wdata_s), .wstrb_s(wstrb_s), .wlast_s(wlast_s), .wvalid_s(wvalid_s),
        .wready_s(wready_s),
        .bid_s(bid_s), .bresp_s(bresp_s), .bvalid_s(bvalid_s), .bready_s(bready_s)
    );

    logic [511:0] ref_mem   [WORDS];
    logic [511:0] wbuf_data [256];
    logic [63:0]  wbuf_strb [256];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic fill_wbuf(input int len, input logic rand_strb);
        for (int k = 0; k <= len; k++) begin
            wbuf_data[k] = rand512();
            wbuf_strb[k] = rand_strb ? {$urandom, $urandom} : '1;
        end
    endtask

    task automatic axi_write(input logic [IDW-1:0] id, input logic [63:0] addr, input int len,
                             input logic [2:0] size, input int wlast_beat, input int bstall);
        logic              exp_flag;
        logic              err;
        longint unsigned   idx;
        int                n;
        exp_flag  = 1'b0;
        awid_s    = id;
        awaddr_s  = addr;
        awlen_s   = len[7:0];
        awsize_s  = size;
        awvalid_s = 1'b1;
        n = 0;
        while (!awready_s && n < 100) begin @(posedge clk); #1; n++; end
        check("aw_ready", awready_s, 1);
        @(posedge clk); #1;
        awvalid_s = 1'b0;
        for (int k = 0; k <= len; k++) begin
            wdata_s  = wbuf_data[k];
            wstrb_s  = wbuf_strb[k];
            wlast_s  = (k == wlast_beat);
            wvalid_s = 1'b1;
            check("w_ready", wready_s, 1);
            idx = (addr >> 6) + longint'(k);
            err = (size != 3'b110) || (idx >= WORDS);
            if (err || ((k == wlast_beat) != (k == len))) exp_flag = 1'b1;
            if (!err) begin
                for (int b = 0; b < 64; b++)
                    if (wbuf_strb[k][b]) ref_mem[int'(idx)][8*b +: 8] = wbuf_data[k][8*b +: 8];
            end
            @(posedge clk); #1;
        end
        wvalid_s = 1'b0;
        wlast_s  = 1'b0;
        check("b_valid", bvalid_s, 1);
        check("b_id", bid_s, id);
        check("b_resp", bresp_s, exp_flag ? 2'b10 : 2'b00);
        for (int c = 0; c < bstall; c++) begin
            @(posedge clk); #1;
            check("b_hold_valid", bvalid_s, 1);
            check("b_hold_resp", bresp_s, exp_flag ? 2'b10 : 2'b00);
            check("b_hold_awready", awready_s, 0);
        end
        bready_s = 1'b1;
        @(posedge clk); #1;
        bready_s = 1'b0;
        check("b_done", bvalid_s, 0);
        check("aw_ready_after_b", awready_s, 1);
    endtask

    task automatic axi_read(input logic [IDW-1:0] id, input logic [63:0] addr, input int len,
                            input logic [2:0] size, input int stall_beat, input int stall_cycles,
                            input int abort_at);
        logic              err;
        longint unsigned   idx;
        logic [511:0]      exp_data;
        int                n;
        arid_s    = id;
        araddr_s  = addr;
        arlen_s   = len[7:0];
        arsize_s  = size;
        arvalid_s = 1'b1;
        n = 0;
        while (!arready_s && n < 100) begin @(posedge clk); #1; n++; end
        check("ar_ready", arready_s, 1);
        @(posedge clk); #1;
        arvalid_s = 1'b0;
        for (int k = 0; k <= len; k++) begin
            n = 0;
            while (!rvalid_s && n < 50) begin @(posedge clk); #1; n++; end
            check("r_latency", n, 1);
            if (k == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_rvalid", rvalid_s, 0);
                check("rst_arready", arready_s, 0);
                return;
            end
            idx = (addr >> 6) + longint'(k);
            err = (size != 3'b110) || (idx >= WORDS);
            exp_data = '0;
            if (!err) exp_data = ref_mem[int'(idx)];
            check("r_id", rid_s, id);
            check("r_data", rdata_s, exp_data);
            check("r_resp", rresp_s, err ? 2'b10 : 2'b00);
            check("r_last", rlast_s, (k == len));
            if (k == stall_beat) begin
                for (int c = 0; c < stall_cycles; c++) begin
                    @(posedge clk); #1;
                    check("r_hold_valid", rvalid_s, 1);
                    check("r_hold_data", rdata_s, exp_data);
                    check("r_hold_resp", rresp_s, err ? 2'b10 : 2'b00);
                    check("r_hold_last", rlast_s, (k == len));
                end
            end
            rready_s = 1'b1;
            @(posedge clk); #1;
            rready_s = 1'b0;
        end
        check("r_idle", rvalid_s, 0);
        check("ar_ready_after_r", arready_s, 1);
    endtask

    initial begin
        int          len, idx, wlb;
        logic [2:0]  sz;
        logic [63:0] addr;

        reset_n   = 1'b0;
        arid_s    = '0; araddr_s = '0; arlen_s = '0; arsize_s = '0; arvalid_s = 1'b0;
        awid_s    = '0; awaddr_s = '0; awlen_s = '0; awsize_s = '0; awvalid_s = 1'b0;
        wdata_s   = '0; wstrb_s  = '0; wlast_s = 1'b0; wvalid_s = 1'b0;
        rready_s  = 1'b0;
        bready_s  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", arready_s, 0);
        check("rst_awready", awready_s, 0);
        check("rst_wready", wready_s, 0);
        check("rst_rvalid", rvalid_s, 0);
        check("rst_rlast", rlast_s, 0);
        check("rst_bvalid", bvalid_s, 0);
        check("rst_rdata", rdata_s, 0);
        check("rst_rresp", rresp_s, 0);
        check("rst_rid", rid_s, 0);
        check("rst_bid", bid_s, 0);
        check("rst_bresp", bresp_s, 0);
        reset_n = 1'b1;
        #1;
        check("arready_before_edge", arready_s, 0);
        @(posedge clk); #1;
        check("arready_after_rst", arready_s, 1);
        check("awready_after_rst", awready_s, 1);

        // Fill the whole array so every later read has a known reference.
        fill_wbuf(WORDS - 1, 1'b0);
        axi_write(16'h0001, 64'h0, WORDS - 1, 3'b110, WORDS - 1, 0);

        for (int k = 0; k < 4; k++) begin
            wbuf_data[k] = {64{k[7:0]}};
            wbuf_strb[k] = '1;
        end
        axi_write(16'h0005, 64'h0, 3, 3'b110, 3, 0);
        axi_read(16'h0007, 64'h0, 3, 3'b110, -1, 0, -1);

        wbuf_data[0] = '1; wbuf_strb[0] = '1;
        axi_write(16'h0002, 64'h40, 0, 3'b110, 0, 0);
        wbuf_data[0] = '0; wbuf_strb[0] = 64'h0000_0000_0000_000F;
        axi_write(16'h0003, 64'h40, 0, 3'b110, 0, 0);
        axi_read(16'h0004, 64'h40, 0, 3'b110, -1, 0, -1);

        addr = 64'(WORDS - 1) << 6;
        axi_read(16'h0010, addr, 1, 3'b110, -1, 0, -1);
        fill_wbuf(1, 1'b0);
        axi_write(16'h0011, addr, 1, 3'b110, 1, 0);
        axi_read(16'h0012, addr, 0, 3'b110, -1, 0, -1);

        fill_wbuf(0, 1'b0);
        axi_write(16'h0020, 64'h80, 0, 3'b101, 0, 0);
        axi_read(16'h0021, 64'h80, 0, 3'b110, -1, 0, -1);
        fill_wbuf(2, 1'b1);
        axi_write(16'h0022, 64'hC0, 2, 3'b110, 0, 0);
        axi_read(16'h0023, 64'hC0, 2, 3'b110, -1, 0, -1);

        axi_read(16'h0030, 64'h0, 5, 3'b110, 2, 10, -1);
        fill_wbuf(1, 1'b1);
        axi_write(16'h0031, 64'h100, 1, 3'b110, 1, 6);

        axi_read(16'h0040, 64'h0, 255, 3'b110, -1, 0, -1);

        axi_read(16'h0050, 64'h40, 3, 3'b110, -1, 0, 2);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_rvalid", rvalid_s, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("arready_after_abort", arready_s, 1);
        axi_read(16'h0051, 64'h40, 3, 3'b110, -1, 0, -1);

        for (int it = 0; it < 40; it++) begin
            idx  = $urandom_range(0, WORDS + 3);
            addr = (64'(idx) << 6) | 64'($urandom_range(0, 63));
            len  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 7);
            sz   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b110;
            if ($urandom_range(0, 1) == 1) begin
                wlb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len + 1) : len;
                fill_wbuf(len, ($urandom_range(0, 1) == 1));
                axi_write(16'($urandom), addr, len, sz, wlb, $urandom_range(0, 3));
            end else begin
                axi_read(16'($urandom), addr, len, sz, $urandom_range(0, len),
                         $urandom_range(0, 3), -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 slave memory responder for the 512-bit accelerator memory port. It accepts INCR read and write bursts from a streaming master such as the AES/XOR engine and services them from an internal word array of 2^ADDR_BITS × 512 bits. Byte strobes are honored, and out-of-range or unsupported requests complete with SLVERR. It is used as on-chip scratch memory and as the bench-side memory model for the team's AXI masters.

## Interface
- ADDR_BITS, 10, word-index width; the array holds 2^ADDR_BITS 64-byte words (default 64 KiB)
- ID_BITS, 16, width of the AXI ID fields
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- arid_s / araddr_s / arlen_s / arsize_s / arvalid_s  in  ID_BITS/64/8/3/1  read address channel
- arready_s  out  1  read address accept
- rid_s / rdata_s / rresp_s / rlast_s / rvalid_s  out  ID_BITS/512/2/1/1  read data channel
- rready_s  in  1  read data accept
- awid_s / awaddr_s / awlen_s / awsize_s / awvalid_s  in  ID_BITS/64/8/3/1  write address channel
- awready_s  out  1  write address accept
- wdata_s / wstrb_s / wlast_s / wvalid_s  in  512/64/1/1  write data channel
- wready_s  out  1  write data accept
- bid_s / bresp_s / bvalid_s  out  ID_BITS/2/1  write response channel
- bready_s  in  1  write response accept

## Operation
- Read and write paths are independent FSMs that share only the array.
- Address decode per beat:
  - word index = addr[6+ADDR_BITS-1:6]; addr[5:0] is ignored.
  - A beat is out of range when addr[63:6+ADDR_BITS] != 0.
  - The burst word index increments by 1 per beat, carried in a 58-bit counter (addr[63:6]); it never wraps within the array.
- Size check: any size other than 3'b110 makes every beat of that burst an error beat.
- Read FSM:
  - R_IDLE: arready_s=1. On AR handshake, latch id, addr, len and the size error, then go to R_FETCH.
  - R_FETCH: array read issued; go to R_DATA.
  - R_DATA: rvalid_s=1; rid_s = latched id; rlast_s=1 on beat number len (beats counted 0..len).
  - Error beat in R_DATA: rresp_s=2'b10 and rdata_s=0. Good beat: rresp_s=2'b00.
  - On R handshake: if last, go to R_IDLE; else increment the index and go to R_FETCH.
- Write FSM:
  - W_IDLE: awready_s=1. On AW handshake, latch id, addr, len and size error; clear the error flag; go to W_DATA.
  - W_DATA: wready_s=1. Each W handshake writes the bytes where wstrb_s[i]=1 (byte i = wdata_s[8i+7:8i]); error beats do not write.
  - The flag is set by any error beat, or by a wlast_s value that disagrees with the responder's own beat count.
  - The burst ends on counted beat len regardless of wlast_s; then go to W_RESP.
  - W_RESP: bvalid_s=1; bid_s = latched id; bresp_s = flag ? 2'b10 : 2'b00. On B handshake, go to W_IDLE.
- Same-word read and write in the same cycle: the read returns the pre-write data.
- Array contents are not reset.

## Timing
- Reset (reset_n low, asynchronously):
  - Both FSMs go to IDLE.
  - arready_s, awready_s, wready_s, rvalid_s, rlast_s and bvalid_s are 0.
  - rdata_s, rresp_s, rid_s, bid_s and bresp_s are 0.
- arready_s and awready_s are 0 while reset_n is low. They equal "state==IDLE" from the first clk edge after deassertion.
- Read latency: AR handshake at cycle T gives rvalid_s at T+2. A non-last R handshake at cycle t gives the next rvalid_s at t+2. Throughput is 1 beat per 2 cycles with zero backpressure.
- Write: AW handshake at T gives wready_s from T+1, at 1 beat/cycle. The last W handshake at t gives bvalid_s at t+1. A B handshake at u gives awready_s at u+1.
- rvalid_s, rdata_s, rresp_s, rlast_s and rid_s hold stable while rvalid_s=1 and rready_s=0. The same holds for bvalid_s, bid_s and bresp_s.
- arready_s=0 outside R_IDLE, so only one outstanding read. awready_s=0 outside W_IDLE, so only one outstanding write.
- A maximum burst (len=255) reads 256 beats; rlast_s asserts on exactly one beat.
- Reset mid-burst abandons the burst: no further R/B beats, and array words already written keep their data.

## Test plan
- Write then read:
  - Stimulus: AW addr 0x0, len 3, size 6, id 0x5; beats k=0..3 with wdata = {64{8'hk}}, full strobe, wlast on k=3.
  - Required: bid_s=0x5, bresp_s=0.
  - Then AR addr 0x0, len 3, id 0x7. Required: four beats, rid_s=0x7, rresp_s=0, data {64{8'hk}}, rlast_s on the 4th beat only.
- Partial strobe:
  - Stimulus: write word 1 with all-0xFF data, then write it again with data 0 and wstrb 64'h0000_0000_0000_000F.
  - Required: read returns bytes 0..3 = 0x00 and bytes 4..63 = 0xFF.
- Out-of-range straddle:
  - Stimulus: AR with addr = (2^ADDR_BITS-1)<<6, len 1.
  - Required: beat 0 has rresp 0 with the stored data; beat 1 has rresp 2'b10 with data 0.
  - Same addressing on a write. Required: bresp 2'b10, and the top word is still written.
- Bad size / wlast mismatch:
  - Stimulus: AW with size 3'b101, len 0. Required: no array write, bresp 2'b10.
  - Stimulus: AW with len 2 and wlast on beat 0. Required: three beats accepted, bresp 2'b10.
- Backpressure:
  - Stimulus: hold rready_s=0 for 10 cycles mid-burst. Required: rdata_s, rresp_s and rlast_s stay constant, and the beat count is unchanged.
  - Stimulus: hold bready_s=0. Required: bvalid_s stays 1 and awready_s stays 0.
- Reset mid-burst:
  - Stimulus: assert reset_n=0 after 2 of 4 read beats.
  - Required: rvalid_s=0 immediately; after release, arready_s=1 and a fresh read returns correct data.
